axi4_lite_regfile: RTL and testbench

AXI4-Lite slave that terminates the master side of the AXI4-Lite interface bundle and exposes a bank of NUM_REGS read/write control registers to surrounding logic. The write channels (AW and W) are buffered independently and committed together. Reads are serviced with one registered cycle of latency. Out-of-range accesses are answered with SLVERR, so a master never hangs.

---
 rtl/axi4_lite_regfile_if.sv | 37 +++
 rtl/axi4_lite_regfile.sv | 137 +++++++++++++
 tb/tb_axi4_lite_regfile.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite bus bundle between a master and the register-file slave.
interface axi4_lite_regfile_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 4
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_BYTES*8-1:0] awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_BYTES*8-1:0] wdata;
    logic [DATA_BYTES-1:0]   wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_BYTES*8-1:0] araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_BYTES*8-1:0] rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS read/write control registers.
// AW and W are buffered independently and committed together; reads
// return one registered cycle after the AR handshake. Out-of-range
// accesses complete with SLVERR.
module axi4_lite_regfile #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    axi4_lite_regfile_if.slave               bus,
    output logic [NUM_REGS*DATA_BYTES*8-1:0] regs_o,
    output logic [NUM_REGS-1:0]              wr_pulse_o
);
    localparam int W     = DATA_BYTES * 8;
    localparam int AW    = ADDR_BYTES * 8;
    localparam int LSB   = $clog2(DATA_BYTES);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [AW-1:0] SPAN = AW'(NUM_REGS * DATA_BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [W-1:0]          regs [NUM_REGS];
    logic                  aw_held;
    logic                  w_held;
    logic [AW-1:0]         awaddr_q;
    logic [W-1:0]          wdata_q;
    logic [DATA_BYTES-1:0] wstrb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [W-1:0]          rdata_q;
    logic [1:0]            rresp_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic                  commit;
    logic [IDX_W-1:0]      widx;
    logic [IDX_W-1:0]      ridx;
    logic                  unused_prot;

    // Addresses beyond the register bank (including any set upper bits) are rejected.
    function automatic logic in_range(input logic [AW-1:0] a);
        return a < SPAN;
    endfunction

    assign unused_prot = ^{bus.awprot, bus.arprot};

    assign bus.awready = !aw_held;
    assign bus.wready  = !w_held;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = !rvalid_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign wr_pulse_o  = wr_pulse_q;

    // Commit once both halves are held and the B slot is free or being freed.
    assign commit = aw_held && w_held && (!bvalid_q || bus.bready);
    assign widx   = awaddr_q[LSB +: IDX_W];
    assign ridx   = bus.araddr[LSB +: IDX_W];

    // Flatten the register array onto the regs_o bus.
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[i*W +: W] = regs[i];
        end
    end

    // Write path: buffer AW and W, then commit byte-enabled data and raise B.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse_q <= '0;
            if (bus.awvalid && !aw_held) begin
                awaddr_q <= bus.awaddr;
                aw_held  <= 1'b1;
            end
            if (bus.wvalid && !w_held) begin
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
                w_held  <= 1'b1;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                if (in_range(awaddr_q)) begin
                    bresp_q          <= RESP_OKAY;
                    wr_pulse_q[widx] <= 1'b1;
                    for (int b = 0; b < DATA_BYTES; b++) begin
                        if (wstrb_q[b]) begin
                            regs[widx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                    end
                end else begin
                    bresp_q <= RESP_SLVERR;
                end
            end else if (bus.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read path: capture the addressed register on AR and hold it until R completes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (bus.arvalid && !rvalid_q) begin
            rvalid_q <= 1'b1;
            if (in_range(bus.araddr)) begin
                rdata_q <= regs[ridx];
                rresp_q <= RESP_OKAY;
            end else begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end
        end else if (rvalid_q && bus.rready) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_axi4_lite_regfile;
    localparam int DB = 4;
    localparam int AB = 4;
    localparam int NR = 16;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [NR*32-1:0]  regs_o;
    logic [NR-1:0]     wr_pulse_o;
    int                vectors = 0;
    int                miscompares = 0;

    axi4_lite_regfile_if #(.DATA_BYTES(DB), .ADDR_BYTES(AB)) bus_if ();

    axi4_lite_regfile #(.DATA_BYTES(DB), .ADDR_BYTES(AB), .NUM_REGS(NR)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .bus        (bus_if),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return regs_o[i*32 +: 32];
    endfunction

    // AW and W in the same cycle with bready high; ends on the cycle bvalid is up.
    task automatic write_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_if.awvalid = 1'b1; bus_if.awaddr = a;
        bus_if.wvalid  = 1'b1; bus_if.wdata  = d; bus_if.wstrb = s;
        bus_if.bready  = 1'b1;
        tick();
        bus_if.awvalid = 1'b0; bus_if.wvalid = 1'b0;
        tick();
    endtask

    initial begin
        bus_if.awvalid = 1'b0; bus_if.awaddr = '0; bus_if.awprot = '0;
        bus_if.wvalid  = 1'b0; bus_if.wdata  = '0; bus_if.wstrb  = '0;
        bus_if.bready  = 1'b0;
        bus_if.arvalid = 1'b0; bus_if.araddr = '0; bus_if.arprot = '0;
        bus_if.rready  = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        tick();

        // Reset state
        chk("rst_bvalid",  32'(bus_if.bvalid),  32'h0);
        chk("rst_rvalid",  32'(bus_if.rvalid),  32'h0);
        chk("rst_awready", 32'(bus_if.awready), 32'h1);
        chk("rst_wready",  32'(bus_if.wready),  32'h1);
        chk("rst_arready", 32'(bus_if.arready), 32'h1);
        chk("rst_bresp",   32'(bus_if.bresp),   32'h0);
        chk("rst_rresp",   32'(bus_if.rresp),   32'h0);
        chk("rst_rdata",   bus_if.rdata,        32'h0);
        chk("rst_pulse",   32'(wr_pulse_o),     32'h0);
        chk("rst_reg2",    reg_of(2),           32'h0);

        // Test 1: AW and W together
        bus_if.awvalid = 1'b1; bus_if.awaddr = 32'h08;
        bus_if.wvalid  = 1'b1; bus_if.wdata  = 32'hDEADBEEF; bus_if.wstrb = 4'hF;
        bus_if.bready  = 1'b1;
        tick();
        chk("t1_awready_held", 32'(bus_if.awready), 32'h0);
        chk("t1_wready_held",  32'(bus_if.wready),  32'h0);
        chk("t1_bvalid_early", 32'(bus_if.bvalid),  32'h0);
        bus_if.awvalid = 1'b0; bus_if.wvalid = 1'b0;
        tick();
        chk("t1_bvalid", 32'(bus_if.bvalid), 32'h1);
        chk("t1_bresp",  32'(bus_if.bresp),  32'h0);
        chk("t1_reg2",   reg_of(2),          32'hDEADBEEF);
        chk("t1_pulse",  32'(wr_pulse_o),    32'h0004);
        tick();
        chk("t1_bvalid_drop", 32'(bus_if.bvalid),  32'h0);
        chk("t1_pulse_drop",  32'(wr_pulse_o),     32'h0);
        chk("t1_awready",     32'(bus_if.awready), 32'h1);

        // Test 2: W three cycles ahead of AW, partial strobe
        write_both(32'h04, 32'hAABBCCDD, 4'hF);
        tick();
        chk("t2_reg1_init", reg_of(1), 32'hAABBCCDD);
        bus_if.wvalid = 1'b1; bus_if.wdata = 32'h11223344; bus_if.wstrb = 4'h5;
        tick();
        bus_if.wvalid = 1'b0;
        chk("t2_wready_low", 32'(bus_if.wready), 32'h0);
        tick(); tick();
        chk("t2_no_commit_b",   32'(bus_if.bvalid), 32'h0);
        chk("t2_no_commit_reg", reg_of(1),          32'hAABBCCDD);
        bus_if.awvalid = 1'b1; bus_if.awaddr = 32'h04;
        tick();
        bus_if.awvalid = 1'b0;
        chk("t2_bvalid_early", 32'(bus_if.bvalid), 32'h0);
        tick();
        chk("t2_bvalid", 32'(bus_if.bvalid), 32'h1);
        chk("t2_reg1",   reg_of(1),          32'hAA22CC44);
        chk("t2_pulse",  32'(wr_pulse_o),    32'h0002);
        tick();

        // Test 3: read with rready stalled for four cycles
        chk("t3_arready_idle", 32'(bus_if.arready), 32'h1);
        bus_if.arvalid = 1'b1; bus_if.araddr = 32'h08; bus_if.rready = 1'b0;
        tick();
        bus_if.arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t3_rvalid",  32'(bus_if.rvalid),  32'h1);
            chk("t3_rdata",   bus_if.rdata,        32'hDEADBEEF);
            chk("t3_rresp",   32'(bus_if.rresp),   32'h0);
            chk("t3_arready", 32'(bus_if.arready), 32'h0);
            tick();
        end
        bus_if.rready = 1'b1;
        tick();
        chk("t3_rvalid_drop", 32'(bus_if.rvalid),  32'h0);
        chk("t3_arready_back", 32'(bus_if.arready), 32'h1);

        // Test 4: out-of-range write and read
        write_both(32'h40, 32'h12345678, 4'hF);
        chk("t4_bvalid", 32'(bus_if.bvalid), 32'h1);
        chk("t4_bresp",  32'(bus_if.bresp),  32'h2);
        chk("t4_pulse",  32'(wr_pulse_o),    32'h0);
        chk("t4_reg0",   reg_of(0),          32'h0);
        chk("t4_reg1",   reg_of(1),          32'hAA22CC44);
        chk("t4_reg2",   reg_of(2),          32'hDEADBEEF);
        tick();
        bus_if.arvalid = 1'b1; bus_if.araddr = 32'h40;
        tick();
        bus_if.arvalid = 1'b0;
        chk("t4_rvalid", 32'(bus_if.rvalid), 32'h1);
        chk("t4_rresp",  32'(bus_if.rresp),  32'h2);
        chk("t4_rdata",  bus_if.rdata,       32'h0);
        tick();

        // Test 5: second pair held behind a stalled B, committed on the B handshake
        bus_if.bready  = 1'b0;
        bus_if.awvalid = 1'b1; bus_if.awaddr = 32'h0C;
        bus_if.wvalid  = 1'b1; bus_if.wdata  = 32'h01010101; bus_if.wstrb = 4'hF;
        tick();
        bus_if.awaddr = 32'h10; bus_if.wdata = 32'h02020202;
        tick();
        chk("t5_b1_valid", 32'(bus_if.bvalid), 32'h1);
        chk("t5_reg3",     reg_of(3),          32'h01010101);
        chk("t5_pulse1",   32'(wr_pulse_o),    32'h0008);
        tick();
        bus_if.awvalid = 1'b0; bus_if.wvalid = 1'b0;
        chk("t5_awready_held", 32'(bus_if.awready), 32'h0);
        chk("t5_wready_held",  32'(bus_if.wready),  32'h0);
        tick(); tick();
        chk("t5_b_still",  32'(bus_if.bvalid), 32'h1);
        chk("t5_reg4_pre", reg_of(4),          32'h0);
        chk("t5_no_pulse", 32'(wr_pulse_o),    32'h0);
        bus_if.bready = 1'b1;
        tick();
        chk("t5_b2_valid", 32'(bus_if.bvalid), 32'h1);
        chk("t5_b2_resp",  32'(bus_if.bresp),  32'h0);
        chk("t5_reg4",     reg_of(4),          32'h02020202);
        chk("t5_pulse2",   32'(wr_pulse_o),    32'h0010);
        tick();
        chk("t5_b_done", 32'(bus_if.bvalid), 32'h0);

        // Test 6: reset mid-transaction abandons the pending write
        bus_if.awvalid = 1'b1; bus_if.awaddr = 32'h14;
        bus_if.arvalid = 1'b1; bus_if.araddr = 32'h08; bus_if.rready = 1'b0;
        tick();
        bus_if.awvalid = 1'b0; bus_if.arvalid = 1'b0;
        chk("t6_aw_held", 32'(bus_if.awready), 32'h0);
        chk("t6_rvalid",  32'(bus_if.rvalid),  32'h1);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_rvalid",  32'(bus_if.rvalid),  32'h0);
        chk("t6_rst_rdata",   bus_if.rdata,        32'h0);
        chk("t6_rst_awready", 32'(bus_if.awready), 32'h1);
        chk("t6_rst_reg2",    reg_of(2),           32'h0);
        chk("t6_rst_reg4",    reg_of(4),           32'h0);
        tick();
        aresetn = 1'b1;
        bus_if.wvalid = 1'b1; bus_if.wdata = 32'hFFFFFFFF; bus_if.wstrb = 4'hF;
        tick();
        bus_if.wvalid = 1'b0;
        tick(); tick();
        chk("t6_no_bvalid", 32'(bus_if.bvalid), 32'h0);
        chk("t6_reg5",      reg_of(5),          32'h0);
        chk("t6_reg0",      reg_of(0),          32'h0);
        chk("t6_no_pulse",  32'(wr_pulse_o),    32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
